// File: rtl/aes_inv_key_sequencer.sv
// aes_inv_key_sequencer: AES-128 decryption round-key generator; expands forward to round NR, then emits round keys NR..0
// Ports: clk, nreset (async active-low); key_v_i/key_i/key_ready_o accept a cipher key in IDLE;
// rkey_v_o/rkey_o/rkey_idx_o/rkey_ready_i hand out round keys in inverse-cipher order; busy_o high in EXPAND or EMIT.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] m;
    p = '0;
    m = x;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (y[i] ? m : 8'h00);
      m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  logic [7:0] t;
  logic [7:0] b;
  // multiplicative inverse as a^254 = (a^127)^2, which maps 0 to 0
  always_comb begin
    t = a;
    for (int i = 0; i < 6; i++) t = gmul(gmul(t, t), a);
    b = gmul(t, t);
    s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  end
endmodule

module aes_inv_key_sequencer #(
  parameter int NR    = 10,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             key_v_i,
  input  logic [127:0]     key_i,
  output logic             key_ready_o,
  output logic             rkey_v_o,
  output logic [127:0]     rkey_o,
  output logic [IDX_W-1:0] rkey_idx_o,
  input  logic             rkey_ready_i,
  output logic             busy_o
);
  typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;
  state_t           state;
  logic [127:0]     key_q;
  logic [7:0]       rcon_q;
  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      w0, w1, w2, w3, p3, sub_in, sub_out, t;
  logic [127:0]     fwd_key, inv_key;
  assign {w0, w1, w2, w3} = key_q;
  assign p3 = w3 ^ w2;
  // the single SubWord unit sees RotWord(w3) going forward and RotWord(w3^w2) going backward
  assign sub_in = state == EMIT ? {p3[23:0], p3[31:24]} : {w3[23:0], w3[31:24]};
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.a(sub_in[8*g +: 8]), .s(sub_out[8*g +: 8]));
  end
  assign t = sub_out ^ {rcon_q, 24'h0};
  assign fwd_key = {w0 ^ t, w1 ^ w0 ^ t, w2 ^ w1 ^ w0 ^ t, w3 ^ w2 ^ w1 ^ w0 ^ t};
  assign inv_key = {w0 ^ t, w1 ^ w0, w2 ^ w1, p3};
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state  <= IDLE;
      key_q  <= '0;
      rcon_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
    end else begin
      case (state)
        IDLE: if (key_v_i) begin
          key_q  <= key_i;
          rcon_q <= 8'h01;
          cnt_q  <= '0;
          state  <= EXPAND;
        end
        EXPAND: begin
          key_q <= fwd_key;
          cnt_q <= cnt_q + IDX_W'(1);
          if (cnt_q == IDX_W'(NR - 1)) begin
            state  <= EMIT;
            idx_q  <= IDX_W'(NR);
            rcon_q <= 8'h36;
          end else begin
            rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
          end
        end
        EMIT: if (rkey_ready_i) begin
          if (idx_q == '0) state <= IDLE;
          else begin
            key_q  <= inv_key;
            idx_q  <= idx_q - IDX_W'(1);
            rcon_q <= rcon_q == 8'h1b ? 8'h80 : rcon_q >> 1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign key_ready_o = state == IDLE;
  assign rkey_v_o    = state == EMIT;
  assign busy_o      = state != IDLE;
  assign rkey_o      = state == EMIT ? key_q : '0;
  assign rkey_idx_o  = idx_q;
endmodule

// File: tb/tb_aes_inv_key_sequencer.sv
// tb_aes_inv_key_sequencer: randomized self-checking bench against a FIPS-197 key-expansion model
module tb_aes_inv_key_sequencer;
  logic         clk = 0;
  logic         nreset = 0;
  logic         key_v_i = 0;
  logic [127:0] key_i = '0;
  logic         key_ready_o;
  logic         rkey_v_o;
  logic [127:0] rkey_o;
  logic [3:0]   rkey_idx_o;
  logic         rkey_ready_i = 0;
  logic         busy_o;
  int passed = 0;
  int total = 0;
  logic [7:0]   sbox [256];
  logic [127:0] exp_rk [11];
  localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_inv_key_sequencer dut (
    .clk(clk), .nreset(nreset), .key_v_i(key_v_i), .key_i(key_i),
    .key_ready_o(key_ready_o), .rkey_v_o(rkey_v_o), .rkey_o(rkey_o),
    .rkey_idx_o(rkey_idx_o), .rkey_ready_i(rkey_ready_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) $display("FAIL %s got=%h exp=%h", tag, got, want);
    else passed++;
  endtask

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    int r = 0;
    int x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = x << 1;
      if (x > 255) x = x ^ 'h11b;
    end
    return 8'(r);
  endfunction

  task automatic build_sbox();
    logic [7:0] c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 0;
      logic [7:0] s;
      for (int y = 1; y < 256; y++) if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox[x] = s;
    end
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [7:0]  rc [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      logic [31:0] tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {tw[23:0], tw[31:24]};
        tw = {sbox[tw[31:24]], sbox[tw[23:16]], sbox[tw[15:8]], sbox[tw[7:0]]} ^ {rc[i/4-1], 24'h0};
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic run_seq(input logic [127:0] k, input bit stall, input bit noise,
                         input bit chain_in, input bit chain_out, input logic [127:0] next_k,
                         input int abort_at);
    model_expand(k);
    if (!chain_in) begin
      int g = 0;
      @(negedge clk);
      while (!key_ready_o && g < 30) begin @(negedge clk); g++; end
    end
    check("ready_before_accept", key_ready_o, 1);
    key_i = k;
    key_v_i = 1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      key_v_i = noise;
      key_i = ~k;
      check($sformatf("expand_c%0d_valid", c), rkey_v_o, 0);
      check($sformatf("expand_c%0d_ready", c), key_ready_o, 0);
      check($sformatf("expand_c%0d_busy", c), busy_o, 1);
    end
    @(negedge clk);
    for (int i = 10; i >= 0; i--) begin
      int g = 0;
      if (i == abort_at) begin
        nreset = 0;
        #1;
        check("abort_valid", rkey_v_o, 0);
        check("abort_rkey", rkey_o, 0);
        check("abort_idx", rkey_idx_o, 0);
        check("abort_busy", busy_o, 0);
        check("abort_ready", key_ready_o, 1);
        @(negedge clk);
        nreset = 1;
        key_v_i = 0;
        rkey_ready_i = 0;
        return;
      end
      forever begin
        bit rr = stall && g < 8 ? 1'($urandom_range(0, 1)) : 1'b1;
        rkey_ready_i = rr;
        if (i == 0 && chain_out) begin key_v_i = 1; key_i = next_k; end
        check($sformatf("emit%0d_valid", i), rkey_v_o, 1);
        check($sformatf("emit%0d_rkey", i), rkey_o, exp_rk[i]);
        check($sformatf("emit%0d_idx", i), rkey_idx_o, 128'(i));
        check($sformatf("emit%0d_keyready", i), key_ready_o, 0);
        @(negedge clk);
        if (rr) break;
        g++;
      end
    end
    rkey_ready_i = 0;
    if (!chain_out) begin
      key_v_i = 0;
      check("idle_valid", rkey_v_o, 0);
      check("idle_ready", key_ready_o, 1);
      check("idle_busy", busy_o, 0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_valid", rkey_v_o, 0);
    check("reset_rkey", rkey_o, 0);
    check("reset_idx", rkey_idx_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_ready", key_ready_o, 1);
    nreset = 1;
    build_sbox();
    model_expand(FIPS);
    check("model_fips_rk10", exp_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("model_fips_rk9", exp_rk[9], 128'hac7766f319fadc2128d12941575c006e);
    check("model_fips_rk1", exp_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    model_expand('0);
    check("model_zero_rk10", exp_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    run_seq(FIPS, 0, 0, 0, 0, '0, -1);
    run_seq('0, 0, 0, 0, 0, '0, -1);
    run_seq(FIPS, 1, 0, 0, 0, '0, -1);
    run_seq(FIPS, 0, 1, 0, 0, '0, -1);
    run_seq(FIPS, 1, 1, 0, 0, '0, 5);
    run_seq(FIPS, 0, 0, 0, 0, '0, -1);
    begin
      logic [127:0] k2 = {$urandom, $urandom, $urandom, $urandom};
      run_seq(FIPS, 0, 0, 0, 1, k2, -1);
      run_seq(k2, 1, 0, 1, 0, '0, -1);
    end
    for (int n = 0; n < 4; n++) begin
      logic [127:0] kr = {$urandom, $urandom, $urandom, $urandom};
      run_seq(kr, 1, n[0], 0, 0, '0, -1);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
